// File: rtl/mem_bus_arbiter.sv
// Two-port SRAM-like arbiter: grants the instruction or data port, translates the
// virtual address, and holds one outstanding transaction on the bridge port.
module mem_bus_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_uncached,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] LG_NONE = 2'd0;
    localparam logic [1:0] LG_INST = 2'd1;
    localparam logic [1:0] LG_DATA = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic        owner_data_q, owner_data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  size_q, size_d;
    logic        wr_q, wr_d;
    logic        uncached_q, uncached_d;

    logic        grant_inst;
    logic        grant_data;
    logic        done;
    logic [31:0] win_vaddr;
    logic [31:0] win_paddr;

    // kseg0/kseg1 fold onto the low 512 MB; everything else is identity-mapped.
    function automatic logic [31:0] mmu(input logic [31:0] va);
        logic [31:0] pa;
        pa = va;
        case (va[31:28])
            4'h8, 4'hA: pa[31:28] = 4'h0;
            4'h9, 4'hB: pa[31:28] = 4'h1;
            default:    pa[31:28] = va[31:28];
        endcase
        return pa;
    endfunction

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (inst_req && data_req) begin
                case (last_grant_q)
                    LG_INST: grant_data = 1'b1;
                    LG_DATA: grant_inst = 1'b1;
                    default: begin
                        grant_data = DATA_FIRST;
                        grant_inst = !DATA_FIRST;
                    end
                endcase
            end else begin
                grant_inst = inst_req;
                grant_data = data_req;
            end
        end
    end

    assign win_vaddr = grant_data ? data_addr : inst_addr;
    assign win_paddr = mmu(win_vaddr);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_data_d = owner_data_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        size_d       = size_q;
        wr_d         = wr_q;
        uncached_d   = uncached_q;
        case (state_q)
            IDLE: begin
                if (grant_inst || grant_data) begin
                    state_d      = REQ;
                    last_grant_d = grant_data ? LG_DATA : LG_INST;
                    owner_data_d = grant_data;
                    addr_d       = win_paddr;
                    uncached_d   = (win_vaddr[31:29] == 3'b101);
                    if (grant_data) begin
                        wr_d    = data_wr;
                        size_d  = data_size;
                        wstrb_d = data_wstrb;
                        wdata_d = data_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        size_d  = 2'd2;
                        wstrb_d = 4'b0000;
                        wdata_d = 32'h0;
                    end
                end
            end
            REQ: begin
                if (bus_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (bus_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LG_NONE;
            owner_data_q <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            size_q       <= 2'd0;
            wr_q         <= 1'b0;
            uncached_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_data_q <= owner_data_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            size_q       <= size_d;
            wr_q         <= wr_d;
            uncached_q   <= uncached_d;
        end
    end

    // A completion racing a reset belongs to the abandoned access and is dropped.
    assign done = (state_q == WAIT) && bus_data_ok && !rst;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = done && !owner_data_q;
    assign data_data_ok = done && owner_data_q;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign bus_req      = (state_q == REQ);
    assign bus_wr       = wr_q;
    assign bus_size     = size_q;
    assign bus_wstrb    = wstrb_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign bus_uncached = uncached_q;

endmodule
